key_conditioner: RTL and testbench
==================================

# key_conditioner

Conditions the four raw DE1-SoC pushbuttons (KEY[3:0], active-low, bouncy, asynchronous) into clean, synchronous, active-high signals for the gate controller. Each key is synchronized, debounced by a per-key counter, and reported as a debounced level plus single-cycle press and release pulses. It sits directly upstream of the gate controller's in1/in2/switch_select/confirm_select inputs and of anything else that reacts to button presses.

## Interface
- DEBOUNCE_CYCLES, 500000: consecutive clk cycles a synchronized key must differ from its debounced state before the change is accepted (10 ms at 50 MHz). Must be ≥ 1.
- CNT_W, $clog2(DEBOUNCE_CYCLES+1): counter width, derived. Not overridden.
- clk  input  1  system clock (CLOCK_50 at top level). One clock; all state is on its rising edge.
- reset  input  1  asynchronous, active-low reset.
- key_raw  input  4  raw KEY[3:0]; 0 = pressed; asynchronous to clk.
- key_level  output  4  debounced state per key; 1 = pressed.
- key_press  output  4  one-cycle pulse per key on accepted press (0→1 of key_level).
- key_release  output  4  one-cycle pulse per key on accepted release (1→0 of key_level).

## Operation
- Per key i, four independent identical channels; no interaction between keys.
- Synchronizer: two flops, sync1 ← ~key_raw[i], sync2 ← sync1. Reset value 0 (released).
- Debounce state: stable (the registered key_level[i]) and cnt (CNT_W bits).
- diff = (sync2 != stable).
- Each clk edge:
  - diff = 0: cnt ← 0; no pulse.
  - diff = 1 and cnt < DEBOUNCE_CYCLES-1: cnt ← cnt+1.
  - diff = 1 and cnt == DEBOUNCE_CYCLES-1: stable ← sync2; cnt ← 0; key_press[i] ← sync2; key_release[i] ← ~sync2.
  - In all other cases key_press[i] and key_release[i] ← 0.
- A bounce (sync2 returning to stable before the count completes) clears cnt; the count restarts from 0 on the next difference.
- cnt never exceeds DEBOUNCE_CYCLES-1 and never wraps.
- key_press and key_release are mutually exclusive per key and never asserted for two consecutive cycles.
- All outputs are registered; no combinational path from key_raw to any output.

## Timing
- Reset (reset = 0, asynchronous): sync1, sync2, stable, cnt, key_level, key_press and key_release are all 0 immediately. No pulse is generated by reset assertion or deassertion.
- Reset mid-count: the count is discarded. A key held through reset is re-detected after release: sync2 = 1 after 2 edges, then one key_press pulse after a further DEBOUNCE_CYCLES edges.
- Latency: key_raw change before edge 0 → sync2 at edge 2 → key_level, key_press/key_release update at edge 2+DEBOUNCE_CYCLES (when held stable throughout).
- The pulse is high for exactly the one cycle following the edge at which key_level changes.
- A key changing state back within fewer than DEBOUNCE_CYCLES consecutive differing cycles produces no output change.
- Simultaneous changes on several keys produce pulses in the same cycle on each affected bit.

## Test plan
- Reset: DEBOUNCE_CYCLES=4; hold reset=0 with key_raw=4'b0000 -> all outputs 0. Release reset -> key_press=4'b1111 for exactly one cycle 6 edges later; key_level=4'b1111 thereafter.
- Clean press/release: DEBOUNCE_CYCLES=4; key_raw[1] 1→0 before edge 0 -> key_level[1]=1 and key_press=4'b0010 after edge 6, key_press=0 after edge 7. Return to 1 -> key_release=4'b0010 six edges later.
- Bounce rejection: DEBOUNCE_CYCLES=4; toggle key_raw[0] low for 3 cycles, high for 1, low for 3, then high -> key_level[0] stays 0; no pulses.
- Accept after bounce: the same bounce, then low held -> key_press[0] fires exactly 6 edges after the final falling transition; one pulse only.
- Simultaneous and independent: key_raw[3] and key_raw[2] fall on the same edge while key_raw[0] is mid-count -> key_press=4'b1100 in one cycle; key_raw[0]'s pulse appears at its own count completion.
- Reset mid-count: key_raw[2] low, assert reset after 3 counting cycles for 1 cycle -> no pulse during reset; key_press[2] fires 6 edges after reset release.

Source files
------------

// File: rtl/key_conditioner.sv
// key_conditioner: synchronize, debounce and edge-detect the four active-low pushbuttons
module key_conditioner #(
    parameter int DEBOUNCE_CYCLES = 500000,
    parameter int CNT_W           = $clog2(DEBOUNCE_CYCLES + 1)
) (
    input  logic       clk,
    input  logic       reset,
    input  logic [3:0] key_raw,
    output logic [3:0] key_level,
    output logic [3:0] key_press,
    output logic [3:0] key_release
);
    localparam logic [CNT_W-1:0] CNT_MAX = CNT_W'(DEBOUNCE_CYCLES - 1);
    logic [3:0]       sync1_q, sync1_d;
    logic [3:0]       sync2_q, sync2_d;
    logic [3:0]       stable_q, stable_d;
    logic [3:0]       press_q, press_d;
    logic [3:0]       release_q, release_d;
    logic [CNT_W-1:0] cnt_q [4];
    logic [CNT_W-1:0] cnt_d [4];
    logic [3:0]       diff;
    logic [3:0]       done;
    // per key: count consecutive differing cycles and accept the new level when the count completes
    always_comb begin
        sync1_d = ~key_raw;
        sync2_d = sync1_q;
        diff    = sync2_q ^ stable_q;
        done    = '0;
        for (int i = 0; i < 4; i++) begin
            done[i]  = diff[i] && (cnt_q[i] == CNT_MAX);
            cnt_d[i] = (!diff[i] || done[i]) ? '0 : cnt_q[i] + CNT_W'(1);
        end
        stable_d  = (done & sync2_q) | (~done & stable_q);
        press_d   = done & sync2_q;
        release_d = done & ~sync2_q;
    end
    // all state resets to the released, idle condition
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            sync1_q   <= '0;
            sync2_q   <= '0;
            stable_q  <= '0;
            press_q   <= '0;
            release_q <= '0;
            for (int i = 0; i < 4; i++) cnt_q[i] <= '0;
        end else begin
            sync1_q   <= sync1_d;
            sync2_q   <= sync2_d;
            stable_q  <= stable_d;
            press_q   <= press_d;
            release_q <= release_d;
            for (int i = 0; i < 4; i++) cnt_q[i] <= cnt_d[i];
        end
    end
    assign key_level   = stable_q;
    assign key_press   = press_q;
    assign key_release = release_q;
endmodule

// File: tb/tb_key_conditioner.sv
// tb_key_conditioner: directed checks of debounce latency, bounce rejection, pulses and reset
module tb_key_conditioner;
    logic       clk = 1'b0;
    logic       reset = 1'b0;
    logic [3:0] key_raw = 4'b0000;
    logic [3:0] key_level, key_press, key_release;
    int errors = 0;
    int checks = 0;

    key_conditioner #(.DEBOUNCE_CYCLES(4)) dut (
        .clk(clk), .reset(reset), .key_raw(key_raw),
        .key_level(key_level), .key_press(key_press), .key_release(key_release)
    );

    always #5 clk = ~clk;

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed=%b expected=%b", tag, obs, exp);
        end
    endtask

    task automatic chk3(input string tag, input logic [3:0] lvl, input logic [3:0] prs, input logic [3:0] rel);
        chk($sformatf("%s.level", tag), key_level, lvl);
        chk($sformatf("%s.press", tag), key_press, prs);
        chk($sformatf("%s.release", tag), key_release, rel);
    endtask

    initial begin
        logic [11:0] bounce;
        // reset held with all keys pressed
        tick(3);
        chk3("in_reset", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b1;
        tick(5);
        chk3("rst_rel_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("rst_rel_e6", 4'b1111, 4'b1111, 4'b0000);
        tick(1);
        chk3("rst_rel_e7", 4'b1111, 4'b0000, 4'b0000);
        key_raw = 4'b1111;
        tick(5);
        chk3("all_rel_e5", 4'b1111, 4'b0000, 4'b0000);
        tick(1);
        chk3("all_rel_e6", 4'b0000, 4'b0000, 4'b1111);
        tick(1);
        chk3("all_rel_e7", 4'b0000, 4'b0000, 4'b0000);
        // clean press and release of key 1
        key_raw = 4'b1101;
        tick(5);
        chk3("k1_press_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("k1_press_e6", 4'b0010, 4'b0010, 4'b0000);
        tick(1);
        chk3("k1_press_e7", 4'b0010, 4'b0000, 4'b0000);
        key_raw = 4'b1111;
        tick(5);
        chk3("k1_rel_e5", 4'b0010, 4'b0000, 4'b0000);
        tick(1);
        chk3("k1_rel_e6", 4'b0000, 4'b0000, 4'b0010);
        tick(1);
        chk3("k1_rel_e7", 4'b0000, 4'b0000, 4'b0000);
        // bounce on key 0: low 3, high 1, low 3, then high; never accepted
        bounce = 12'b1111_1000_1000;
        for (int i = 0; i < 12; i++) begin
            key_raw = {3'b111, bounce[i]};
            tick(1);
            chk3($sformatf("bounce_%0d", i), 4'b0000, 4'b0000, 4'b0000);
        end
        // same bounce, then low held: accepted 6 edges after the final fall
        key_raw = 4'b1110; tick(3);
        key_raw = 4'b1111; tick(1);
        key_raw = 4'b1110;
        tick(5);
        chk3("k0_acc_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("k0_acc_e6", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        chk3("k0_acc_e7", 4'b0001, 4'b0000, 4'b0000);
        tick(3);
        chk3("k0_acc_e10", 4'b0001, 4'b0000, 4'b0000);
        key_raw = 4'b1111;
        tick(6);
        chk3("k0_rel_e6", 4'b0000, 4'b0000, 4'b0001);
        tick(1);
        chk3("k0_rel_e7", 4'b0000, 4'b0000, 4'b0000);
        // key 0 mid-count while keys 3 and 2 fall together
        key_raw = 4'b1110;
        tick(2);
        key_raw = 4'b0010;
        tick(3);
        chk3("sim_e3", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("sim_k0", 4'b0001, 4'b0001, 4'b0000);
        tick(1);
        chk3("sim_e5", 4'b0001, 4'b0000, 4'b0000);
        tick(1);
        chk3("sim_k32", 4'b1101, 4'b1100, 4'b0000);
        tick(1);
        chk3("sim_e7", 4'b1101, 4'b0000, 4'b0000);
        key_raw = 4'b1111;
        tick(6);
        chk3("sim_rel", 4'b0000, 4'b0000, 4'b1101);
        tick(1);
        // reset in the middle of a key 2 count
        key_raw = 4'b1011;
        tick(4);
        chk3("mid_cnt", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b0;
        #1;
        chk3("mid_rst_async", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("mid_rst_held", 4'b0000, 4'b0000, 4'b0000);
        reset = 1'b1;
        tick(5);
        chk3("mid_rst_e5", 4'b0000, 4'b0000, 4'b0000);
        tick(1);
        chk3("mid_rst_e6", 4'b0100, 4'b0100, 4'b0000);
        tick(1);
        chk3("mid_rst_e7", 4'b0100, 4'b0000, 4'b0000);
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end
endmodule
